mvm_driver: RTL and testbench
=============================

MVM_DRIVER -- requirements
Module: mvm_driver

Interface
REQ-001 Parameters SHALL be: K, default 12, matrix dimension and vector length; B, default 12, element width in bits; NW, derived K*K+K, words per job.
REQ-002 clk  input  1  single clock; all logic SHALL sample on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_data  input  B  signed job word (matrix row-major, then vector).
REQ-005 in_valid / in_ready  input / output  1 each  upstream handshake; a word transfers when both are high.
REQ-006 out_data  output  2B  signed result word.
REQ-007 out_valid / out_ready  output / input  1 each  downstream handshake; a word transfers when both are high.
REQ-008 loadMatrix, loadVector, start  output  1 each  MVM control pulses.
REQ-009 mvm_data_in  output  B  element stream to the MVM.
REQ-010 done  input  1  MVM completion pulse.
REQ-011 mvm_data_out  input  2B  MVM result stream.
REQ-012 busy  output  1  high in every state except FILL with an empty staging buffer.
REQ-013 busy_cycles  output  32  performance count (see Configuration).

Function
REQ-014 The FSM SHALL have the states FILL, LOADM, STRM, LOADV, STRV, GO, WAIT, CAP and DRAIN.
REQ-015 FILL: in_ready=1; each transfer writes staging[wr_idx] and increments wr_idx; on the NW-th transfer the FSM SHALL go to LOADM.
REQ-016 LOADM: loadMatrix=1 for exactly 1 cycle, then STRM.
REQ-017 STRM: mvm_data_in SHALL equal staging[0..K*K-1] on K*K consecutive cycles with no gaps, then LOADV.
REQ-018 LOADV: loadVector=1 for exactly 1 cycle, then STRV.
REQ-019 STRV: mvm_data_in SHALL equal staging[K*K..NW-1] on K consecutive cycles, then GO.
REQ-020 GO: start=1 for 1 cycle, then WAIT.
REQ-021 WAIT: the FSM SHALL hold until done=1, then go to CAP.
REQ-022 CAP: mvm_data_out SHALL be captured into the result FIFO on K consecutive cycles, starting the cycle after done; then DRAIN.
REQ-023 DRAIN: results SHALL be presented in FIFO order; when the last result transfers, the FSM SHALL return to FILL with wr_idx=0.
REQ-024 Staging reads SHALL be registered, 1-cycle read latency; mvm_data_in SHALL be aligned so that word n appears on cycle n of its stream window.
REQ-025 Control outputs SHALL be registered and glitch-free; at most one of loadMatrix, loadVector or start SHALL be high in any cycle.
REQ-026 in_ready SHALL be 0 outside FILL; words offered then SHALL NOT be consumed.
REQ-027 out_valid SHALL be 1 only in DRAIN while the FIFO is non-empty; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 A done pulse outside WAIT SHALL be ignored.
REQ-029 mvm_data_in SHALL be 0 outside STRM/STRV.
REQ-030 The result FIFO depth SHALL be K; it cannot overflow, because CAP is entered only with an empty FIFO.

Reset
REQ-031 reset SHALL force, on the next edge: state=FILL, wr_idx=0, FIFO empty.
REQ-032 Reset output values SHALL be: in_ready=0 during the reset cycle, then 1; out_valid=0, loadMatrix=0, loadVector=0, start=0, mvm_data_in=0, busy=0, busy_cycles=0.
REQ-033 reset asserted mid-job (any state) SHALL abandon the job; partial staging contents SHALL be discarded.

Configuration
REQ-034 Macro MVM_DRIVER_PERF_CNT_EN defined: busy_cycles SHALL clear in GO and increment every cycle in WAIT, saturating at 2^32-1, and SHALL hold its value otherwise.
REQ-035 Macro MVM_DRIVER_PERF_CNT_EN undefined: busy_cycles SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-036 Package mvm_drv_pkg SHALL hold the state enum type and the default K and B localparams.
REQ-037 Sub-module drv_fifo SHALL implement the parameterised (width, depth) synchronous result FIFO with full/empty flags; staging SHALL be an inline register array.

Verification
REQ-038 K=2, job words 1,2,3,4,5,6 with in_valid held high -> loadMatrix pulses 1 cycle after the 6th accept; mvm_data_in=1,2,3,4 then loadVector, then 5,6 then start.
REQ-039 Model MVM (K=2) returns 17,39 after done with out_ready=1 -> out_data 17 then 39; FSM back in FILL; in_ready=1.
REQ-040 in_valid toggled every other cycle during FILL -> the MVM stream still has no gaps and has identical content.
REQ-041 out_ready=0 for 5 cycles in DRAIN -> out_data stable and out_valid held high; in_ready stays 0.
REQ-042 reset asserted in STRM, then a fresh 6-word job -> no stale words reach mvm_data_in; outputs equal their reset values.
REQ-043 With MVM_DRIVER_PERF_CNT_EN and done arriving 7 cycles after start -> busy_cycles=7 (checked against a build without the macro, where it reads 0).

Source files
------------

// File: rtl/mvm_drv_pkg.sv
// Shared types and defaults for the matrix-vector-multiply driver: FSM state
// encoding, default dimension/width, and a width helper safe for tiny sizes.
package mvm_drv_pkg;

  localparam int K_DEF = 12;
  localparam int B_DEF = 12;

  typedef enum logic [3:0] {
    FILL,
    LOADM,
    STRM,
    LOADV,
    STRV,
    GO,
    WAIT,
    CAP,
    DRAIN
  } state_t;

  // Index width that never collapses to zero bits for degenerate sizes.
  function automatic int ceil_log2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvm_driver_if.sv
// Control/data bus between the driver (master) and the MVM engine (slave):
// load/start pulses, element stream in, completion pulse and result stream out.
interface mvm_driver_if
  import mvm_drv_pkg::*;
#(
  parameter int B = B_DEF
) ();

  logic           loadMatrix;
  logic           loadVector;
  logic           start;
  logic [B-1:0]   mvm_data_in;
  logic           done;
  logic [2*B-1:0] mvm_data_out;

  modport master (
    output loadMatrix,
    output loadVector,
    output start,
    output mvm_data_in,
    input  done,
    input  mvm_data_out
  );

  modport slave (
    input  loadMatrix,
    input  loadVector,
    input  start,
    input  mvm_data_in,
    output done,
    output mvm_data_out
  );

endinterface

// File: rtl/mvm_driver_fifo.sv
// Small synchronous FIFO (module drv_fifo) holding one job's results; the head
// entry is visible combinationally so the downstream word is stable while stalled.
module drv_fifo
  import mvm_drv_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = ceil_log2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mvm_driver.sv
// Stages one K*K matrix + K vector job, streams it to an MVM engine, captures K
// results and drains them downstream. MVM_DRIVER_PERF_CNT_EN adds a WAIT-cycle counter.
module mvm_driver
  import mvm_drv_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int B  = B_DEF,
  parameter int NW = K * K + K
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [B-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*B-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  mvm_driver_if.master   mvm,
  output logic           busy,
  output logic [31:0]    busy_cycles
);

  localparam int IW = ceil_log2(NW);
  localparam int KK = K * K;

  state_t         state_reg;
  state_t         state_next;
  logic [IW-1:0]  wr_idx_reg;
  logic [IW-1:0]  wr_idx_next;
  logic [IW-1:0]  cnt_reg;
  logic [IW-1:0]  cnt_next;
  logic [IW-1:0]  rd_addr;
  logic           stream_next;

  logic [B-1:0]   staging [NW];

  logic           in_ready_reg;
  logic           load_matrix_reg;
  logic           load_vector_reg;
  logic           start_reg;
  logic [B-1:0]   mvm_data_in_reg;

  logic           fill_xfer;
  logic           out_xfer;
  logic           fifo_push;
  logic           fifo_full;
  logic           fifo_empty;
  logic [2*B-1:0] fifo_dout;

  assign fill_xfer = (state_reg == FILL) && in_ready_reg && in_valid;
  assign out_valid = (state_reg == DRAIN) && !fifo_empty;
  assign out_xfer  = out_valid && out_ready;
  assign fifo_push = (state_reg == CAP) && !fifo_full;
  assign out_data  = fifo_dout;

  assign in_ready        = in_ready_reg;
  assign mvm.loadMatrix  = load_matrix_reg;
  assign mvm.loadVector  = load_vector_reg;
  assign mvm.start       = start_reg;
  assign mvm.mvm_data_in = mvm_data_in_reg;

  assign busy = !((state_reg == FILL) && (wr_idx_reg == '0));

  // rd_addr runs one word ahead of the stream so the registered read lands
  // word n on cycle n of the STRM/STRV window.
  always_comb begin
    state_next  = state_reg;
    wr_idx_next = wr_idx_reg;
    cnt_next    = cnt_reg;
    rd_addr     = '0;
    case (state_reg)
      FILL: begin
        if (fill_xfer) begin
          if (wr_idx_reg == IW'(NW - 1)) begin
            wr_idx_next = '0;
            state_next  = LOADM;
          end else begin
            wr_idx_next = wr_idx_reg + IW'(1);
          end
        end
      end
      LOADM: begin
        state_next = STRM;
        cnt_next   = '0;
        rd_addr    = '0;
      end
      STRM: begin
        if (cnt_reg == IW'(KK - 1)) begin
          state_next = LOADV;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + IW'(1);
          rd_addr  = cnt_reg + IW'(1);
        end
      end
      LOADV: begin
        state_next = STRV;
        cnt_next   = '0;
        rd_addr    = IW'(KK);
      end
      STRV: begin
        if (cnt_reg == IW'(K - 1)) begin
          state_next = GO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + IW'(1);
          rd_addr  = IW'(KK) + cnt_reg + IW'(1);
        end
      end
      GO: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (mvm.done) begin
          state_next = CAP;
          cnt_next   = '0;
        end
      end
      CAP: begin
        if (cnt_reg == IW'(K - 1)) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + IW'(1);
        end
      end
      DRAIN: begin
        if (out_xfer) begin
          if (cnt_reg == IW'(K - 1)) begin
            state_next = FILL;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + IW'(1);
          end
        end
      end
      default: begin
        state_next = FILL;
        cnt_next   = '0;
      end
    endcase
  end

  assign stream_next = (state_next == STRM) || (state_next == STRV);

  always_ff @(posedge clk) begin
    if (fill_xfer) begin
      staging[wr_idx_reg] <= in_data;
    end
  end

  // Control pulses decode the next state so they coincide with the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= FILL;
      wr_idx_reg      <= '0;
      cnt_reg         <= '0;
      in_ready_reg    <= 1'b0;
      load_matrix_reg <= 1'b0;
      load_vector_reg <= 1'b0;
      start_reg       <= 1'b0;
      mvm_data_in_reg <= '0;
    end else begin
      state_reg       <= state_next;
      wr_idx_reg      <= wr_idx_next;
      cnt_reg         <= cnt_next;
      in_ready_reg    <= (state_next == FILL);
      load_matrix_reg <= (state_next == LOADM);
      load_vector_reg <= (state_next == LOADV);
      start_reg       <= (state_next == GO);
      mvm_data_in_reg <= stream_next ? staging[rd_addr] : '0;
    end
  end

  drv_fifo #(
    .W     (2 * B),
    .DEPTH (K)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (mvm.mvm_data_out),
    .pop   (out_xfer),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef MVM_DRIVER_PERF_CNT_EN
  logic [31:0] busy_cycles_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cycles_reg <= '0;
    end else if (state_reg == GO) begin
      busy_cycles_reg <= '0;
    end else if ((state_reg == WAIT) && (busy_cycles_reg != '1)) begin
      busy_cycles_reg <= busy_cycles_reg + 32'd1;
    end
  end

  assign busy_cycles = busy_cycles_reg;
`else
  assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_mvm_driver.sv
// Randomized bench for mvm_driver (K=2): a stand-in MVM engine plus a queue-based
// scoreboard of expected element streams and matrix-vector products.
module tb_mvm_driver;
  import mvm_drv_pkg::*;

  localparam int K  = 2;
  localparam int B  = 12;
  localparam int NW = K * K + K;
  localparam int KK = K * K;

  typedef logic [B-1:0] job_t [NW];

  logic           clk = 1'b0;
  logic           reset;
  logic [B-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [2*B-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  logic [31:0]    busy_cycles;

  mvm_driver_if #(.B(B)) mif ();

  mvm_driver #(.K(K), .B(B)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .mvm         (mif),
    .busy        (busy),
    .busy_cycles (busy_cycles)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int results_seen = 0;
  int done_dly = 1;
  bit stray_done = 1'b0;

  logic [B-1:0]   exp_stream_q [$];
  logic [2*B-1:0] exp_res_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // y[r] = sum_c M[r][c] * v[c], signed, truncated to the 2B-bit result width.
  function automatic logic [2*B-1:0] ref_y(input job_t w, input int r);
    longint acc;
    acc = 0;
    for (int c = 0; c < K; c++)
      acc += longint'($signed(w[r*K+c])) * longint'($signed(w[KK+c]));
    return acc[2*B-1:0];
  endfunction

  // Stand-in MVM engine: checks the control/stream protocol, then answers.
  task automatic mvm_job();
    job_t ew;
    job_t cw;
    logic [2*B-1:0] y [K];
    int dly;
    bit stray;
    dly   = done_dly;
    stray = stray_done;
    chk("din_ldm", mif.mvm_data_in, '0);
    if (exp_stream_q.size() < NW) begin
      chk("stream_q", exp_stream_q.size(), NW);
      return;
    end
    for (int i = 0; i < NW; i++) ew[i] = exp_stream_q.pop_front();
    for (int i = 0; i < NW; i++) begin
      if (i == KK) begin
        @(negedge clk);
        if (reset) begin mif.done = 1'b0; return; end
        chk("ldv_pulse", {mif.loadMatrix, mif.loadVector, mif.start}, 3'b010);
        chk("din_ldv", mif.mvm_data_in, '0);
      end
      @(negedge clk);
      if (reset) begin mif.done = 1'b0; return; end
      mif.done = stray && (i == KK);
      chk("ctl_strm", {mif.loadMatrix, mif.loadVector, mif.start}, 3'b000);
      chk("mvm_in", mif.mvm_data_in, ew[i]);
      cw[i] = mif.mvm_data_in;
    end
    @(negedge clk);
    mif.done = 1'b0;
    if (reset) return;
    chk("start_pulse", {mif.loadMatrix, mif.loadVector, mif.start}, 3'b001);
    chk("din_go", mif.mvm_data_in, '0);
    for (int r = 0; r < K; r++) y[r] = ref_y(cw, r);
    for (int c = 0; c < dly; c++) begin
      @(negedge clk);
      if (reset) return;
    end
    mif.done = 1'b1;
    for (int r = 0; r < K; r++) begin
      @(negedge clk);
      mif.done = 1'b0;
      if (reset) return;
      mif.mvm_data_out = y[r];
    end
    @(negedge clk);
    mif.mvm_data_out = (2*B)'($urandom);
  endtask

  initial begin : mvm_model
    mif.done = 1'b0;
    mif.mvm_data_out = '0;
    forever begin
      @(negedge clk);
      if (!reset && mif.loadMatrix === 1'b1) begin
        mvm_job();
      end else if (!reset) begin
        chk("ctl_idle", {mif.loadVector, mif.start}, 2'b00);
        chk("din_idle", mif.mvm_data_in, '0);
      end
    end
  end

  initial begin : consumer
    logic prev_stall;
    logic [2*B-1:0] prev_data;
    logic [2*B-1:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("ov_hold", out_valid, 1'b1);
          chk("od_hold", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          if (exp_res_q.size() == 0) begin
            chk("res_extra", exp_res_q.size(), 1);
          end else begin
            e = exp_res_q.pop_front();
            chk("out_data", out_data, e);
            $display("result %0d: out_data=%0d expected=%0d", results_seen,
                     $signed(out_data), $signed(e));
            results_seen++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  task automatic reset_checks();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ldm", mif.loadMatrix, 1'b0);
    chk("rst_ldv", mif.loadVector, 1'b0);
    chk("rst_start", mif.start, 1'b0);
    chk("rst_din", mif.mvm_data_in, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_busy_cycles", busy_cycles, 32'd0);
  endtask

  task automatic push_expect(input job_t w);
    for (int i = 0; i < NW; i++) exp_stream_q.push_back(w[i]);
    for (int r = 0; r < K; r++) exp_res_q.push_back(ref_y(w, r));
  endtask

  // mode 0: in_valid held high, 1: toggled every other cycle, 2: random gaps.
  task automatic send_job(input job_t w, input int mode);
    int idx;
    int t;
    bit acc;
    idx = 0;
    t = 0;
    @(posedge clk); #1;
    while (idx < NW && t < 200) begin
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 0) : ($urandom_range(0, 1) == 1);
      in_data  = in_valid ? w[idx] : B'($urandom);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      t++;
    end
    in_valid = 1'b0;
    if (idx < NW) chk("send_timeout", idx, NW);
    @(negedge clk);
    chk("ldm_latency", mif.loadMatrix, 1'b1);
    chk("busy_job", busy, 1'b1);
  endtask

  // ready_mode 0: out_ready high, 1: random, 2: five-cycle stall at DRAIN start.
  task automatic run_job(input job_t w, input int mode, input int dly, input bit stray,
                         input int ready_mode);
    int target;
    int cyc;
    logic [31:0] exp_bc;
    done_dly   = dly;
    stray_done = stray;
    target     = results_seen + K;
    push_expect(w);
    out_ready  = (ready_mode != 2);
    send_job(w, mode);
    if (ready_mode == 2) begin
      cyc = 0;
      while (!out_valid && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      chk("drain_reached", out_valid, 1'b1);
      for (int s = 0; s < 5; s++) begin
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = B'($urandom);
        @(negedge clk);
        chk("ov_stall", out_valid, 1'b1);
        chk("rdy_stall", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    for (cyc = 0; cyc < 400 && results_seen < target; cyc++) begin
      @(posedge clk); #1;
      out_ready = (ready_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
    if (results_seen < target) chk("job_timeout", results_seen, target);
    out_ready = 1'b1;
    @(negedge clk);
    chk("rdy_fill", in_ready, 1'b1);
    chk("busy_idle", busy, 1'b0);
`ifdef MVM_DRIVER_PERF_CNT_EN
    exp_bc = 32'(dly);
`else
    exp_bc = 32'd0;
`endif
    chk("busy_cycles", busy_cycles, exp_bc);
  endtask

  task automatic abort_job(input job_t w);
    done_dly   = 4;
    stray_done = 1'b0;
    push_expect(w);
    send_job(w, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_stream_q.delete();
    exp_res_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rdy_after_abort", in_ready, 1'b1);
  endtask

  task automatic rand_job(output job_t w);
    for (int i = 0; i < NW; i++) w[i] = B'($urandom);
  endtask

  initial begin : main
    job_t w;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rdy_after_rst", in_ready, 1'b1);

    for (int i = 0; i < NW; i++) w[i] = B'(i + 1);
    $display("job fixed 1..6, valid held high, done after 7");
    run_job(w, 0, 7, 1'b0, 0);
    $display("job fixed 1..6, valid toggled");
    run_job(w, 1, 3, 1'b0, 0);

    rand_job(w);
    $display("job random, downstream stall, stray done");
    run_job(w, 2, $urandom_range(1, 10), 1'b1, 2);

    rand_job(w);
    $display("job random, reset in STRM");
    abort_job(w);
    rand_job(w);
    $display("job random after reset");
    run_job(w, 0, 5, 1'b0, 0);

    for (int j = 0; j < 6; j++) begin
      rand_job(w);
      $display("job random %0d", j);
      run_job(w, $urandom_range(0, 2), $urandom_range(1, 12), 1'($urandom_range(0, 1)),
              $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
